damage_scheduler: RTL

Sequences all player-damage events into the health datapath. Latches hit requests from up to NUM_SRC independent collision sources and grants at most one per frame using round-robin priority. After each grant it enforces a frame-counted invulnerability window and detects the killing hit. It sits between the collision detectors and the health register/7-segment display, and drives the game-over request into the main FSM.

---
 rtl/damage_pkg.sv | 22 ++
 rtl/damage_scheduler_if.sv | 25 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/damage_scheduler.sv | 115 +++++++++++
 4 files changed

// File: rtl/damage_pkg.sv
// rtl/damage_pkg.sv - shared state encoding and constants for the damage scheduler
package damage_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_INVULN = 2'd2;
  localparam logic [1:0] ST_DEAD   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_APPLY  = ST_APPLY,
    S_INVULN = ST_INVULN,
    S_DEAD   = ST_DEAD
  } state_t;

  localparam logic [7:0] HIT_CNT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == HIT_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/damage_scheduler_if.sv
// rtl/damage_scheduler_if.sv - hit request / health update bundle between game logic and the scheduler
interface damage_scheduler_if #(parameter int NUM_SRC = 4);

  logic               frame_tick;
  logic [NUM_SRC-1:0] hit_req;
  logic [3:0]         health_in;
  logic               restart;
  logic               update_health;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] pending;
  logic               invuln;
  logic               game_over;
  logic [7:0]         hits_taken;

  modport master (
    output frame_tick, hit_req, health_in, restart,
    input  update_health, grant, pending, invuln, game_over, hits_taken
  );

  modport slave (
    input  frame_tick, hit_req, health_in, restart,
    output update_health, grant, pending, invuln, game_over, hits_taken
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at ptr, wrapping modulo NUM_SRC
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int PW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [PW-1:0]      idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = (int'(ptr) + k) % NUM_SRC;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/damage_scheduler.sv
// rtl/damage_scheduler.sv - one round-robin hit per frame, invulnerability window, kill detection
module damage_scheduler
  import damage_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int INVULN_FRAMES = 30
) (
  input  logic                clk,
  input  logic                resetn,
  damage_scheduler_if.slave   bus
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t             state_q;
  logic [NUM_SRC-1:0] pending_q, grant_q, cand, arb_gnt;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d, arb_idx;
  logic               kill_q, update_q, invuln_q, game_over_q;
  logic [7:0]         inv_cnt_q, hits_q, hits_d;

  // A request raised in the same cycle as frame_tick still competes this frame.
  assign cand     = pending_q | bus.hit_req;
  assign rr_ptr_d = (arb_idx == PW'(NUM_SRC - 1)) ? '0 : arb_idx + PW'(1);
  assign hits_d   = sat_inc(hits_q);

  rr_arbiter #(.NUM_SRC(NUM_SRC), .PW(PW)) u_arb (
    .req (cand),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      kill_q      <= 1'b0;
      update_q    <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
      inv_cnt_q   <= '0;
      hits_q      <= '0;
    end else if (bus.restart) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      kill_q      <= 1'b0;
      update_q    <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
      inv_cnt_q   <= '0;
      hits_q      <= '0;
    end else begin
      update_q <= 1'b0;
      grant_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (bus.frame_tick && (|cand)) begin
            state_q   <= S_APPLY;
            update_q  <= 1'b1;
            grant_q   <= arb_gnt;
            pending_q <= '0;
            rr_ptr_q  <= rr_ptr_d;
            kill_q    <= (bus.health_in <= 4'd1);
          end else begin
            pending_q <= cand;
          end
        end
        S_APPLY: begin
          pending_q <= '0;
          hits_q    <= hits_d;
          if (kill_q) begin
            state_q     <= S_DEAD;
            game_over_q <= 1'b1;
          end else if (INVULN_FRAMES == 0) begin
            state_q <= S_IDLE;
          end else begin
            state_q   <= S_INVULN;
            inv_cnt_q <= 8'(INVULN_FRAMES);
            invuln_q  <= 1'b1;
          end
        end
        S_INVULN: begin
          pending_q <= '0;
          if (bus.frame_tick) begin
            if (inv_cnt_q == 8'd1) begin
              state_q   <= S_IDLE;
              invuln_q  <= 1'b0;
              inv_cnt_q <= '0;
            end else begin
              inv_cnt_q <= inv_cnt_q - 8'd1;
            end
          end
        end
        S_DEAD: begin
          pending_q <= '0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.update_health = update_q;
  assign bus.grant         = grant_q;
  assign bus.pending       = pending_q;
  assign bus.invuln        = invuln_q;
  assign bus.game_over     = game_over_q;
  assign bus.hits_taken    = hits_q;

endmodule
